// File: rtl/pen_locator.sv
// Light-pen position decoder: aligns the pen edge with the pixel driven PEN_LAT
// cycles earlier and locks a coordinate after HITS matching hits.
// Optional macro PEN_GREEN_EN: when defined, green columns also count as lit.
module pen_locator #(
  parameter int unsigned PEN_LAT = 4,
  parameter int unsigned HITS    = 3,
  parameter int unsigned TIMEOUT = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pen_i,
  input  logic [7:0] row_i,
  input  logic [7:0] col_r_i,
  input  logic [7:0] col_g_i,
  output logic [2:0] pos_row_o,
  output logic [2:0] pos_col_o,
  output logic       pos_valid_o,
  output logic       pen_err_o,
  output logic       pen_lost_o
);

  localparam logic [3:0]  HITS_C = 4'(HITS);
  localparam logic [23:0] T_LAST = 24'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [5:0] pix;   // {row, col}
  } tap_t;

  // ---------------------------------------------------------------------------
  // Pixel decode
  // ---------------------------------------------------------------------------
  logic [7:0] lit;
  logic [3:0] row_zeros;
  logic [3:0] col_ones;
  logic [2:0] r_idx;
  logic [2:0] c_idx;
  tap_t       cur;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
`ifdef PEN_GREEN_EN
    lit = col_r_i | col_g_i;
`else
    lit = col_r_i;
`endif
    row_zeros = '0;
    col_ones  = '0;
    r_idx     = '0;
    c_idx     = '0;
    for (int i = 0; i < 8; i++) begin
      if (!row_i[i]) begin
        row_zeros = row_zeros + 4'd1;
        r_idx     = 3'(i);
      end
      if (lit[i]) begin
        col_ones = col_ones + 4'd1;
        c_idx    = 3'(i);
      end
    end
    cur.ok  = (row_zeros == 4'd1) && (col_ones == 4'd1);
    cur.pix = {r_idx, c_idx};
  end

  // dl[0] is the newest entry; dl[PEN_LAT] is the one the pen is answering now.
  tap_t dl [0:PEN_LAT];
  tap_t tap;
  assign tap = dl[PEN_LAT];

  // NOTE: this small array is reset on purpose: a stale ok bit after reset
  // would let the first pen edge lock onto a pixel that was never driven.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= PEN_LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= cur;
      for (int i = 1; i <= PEN_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Pen synchronizer and edge detect (registered, so the FSM acts at E+3)
  // ---------------------------------------------------------------------------
  logic [2:0] sync_q;   // [0]=ff1, [1]=ff2, [2]=ff3 history
  logic       edge_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], pen_i};
      edge_q <= sync_q[1] & ~sync_q[2];
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking FSM
  // ---------------------------------------------------------------------------
  state_t      state, state_d;
  logic [5:0]  cand, cand_d;
  logic [3:0]  hit_cnt, hit_d;
  logic [23:0] tcnt, tcnt_d;
  logic [5:0]  pos_d;
  logic        valid_d, err_d, lost_d;

  always_comb begin
    state_d = state;
    cand_d  = cand;
    hit_d   = hit_cnt;
    tcnt_d  = (state != IDLE) ? tcnt + 24'd1 : '0;
    pos_d   = {pos_row_o, pos_col_o};
    valid_d = 1'b0;
    err_d   = 1'b0;
    lost_d  = 1'b0;

    if (edge_q && !tap.ok) begin
      // Blank or ambiguous tap: report it and leave tracking untouched.
      err_d  = 1'b1;
      tcnt_d = tcnt;
    end else if (edge_q) begin
      tcnt_d = '0;
      unique case (state)
        IDLE: begin
          cand_d = tap.pix;
          hit_d  = 4'd1;
          if (HITS_C == 4'd1) begin
            state_d = LOCK;
            pos_d   = tap.pix;
            valid_d = 1'b1;
          end else begin
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (tap.pix == cand) begin
            if (hit_cnt + 4'd1 >= HITS_C) begin
              hit_d   = HITS_C;
              state_d = LOCK;
              pos_d   = cand;
              valid_d = 1'b1;
            end else begin
              hit_d = hit_cnt + 4'd1;
            end
          end else begin
            cand_d = tap.pix;
            hit_d  = 4'd1;
          end
        end
        LOCK: begin
          if (tap.pix != cand) begin
            state_d = TRACK;
            cand_d  = tap.pix;
            hit_d   = 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state != IDLE && tcnt == T_LAST) begin
      state_d = IDLE;
      hit_d   = '0;
      tcnt_d  = '0;
      lost_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      hit_cnt     <= '0;
      tcnt        <= '0;
      pos_row_o   <= '0;
      pos_col_o   <= '0;
      pos_valid_o <= 1'b0;
      pen_err_o   <= 1'b0;
      pen_lost_o  <= 1'b0;
    end else begin
      state       <= state_d;
      cand        <= cand_d;
      hit_cnt     <= hit_d;
      tcnt        <= tcnt_d;
      pos_row_o   <= pos_d[5:3];
      pos_col_o   <= pos_d[2:0];
      pos_valid_o <= valid_d;
      pen_err_o   <= err_d;
      pen_lost_o  <= lost_d;
    end
  end

endmodule

// File: tb/tb_pen_locator.sv
// Directed bench for pen_locator: lock, latency alignment, ambiguous taps,
// candidate change, timeout, colour masking, held pen and mid-run reset.
module tb_pen_locator;

  localparam int PEN_LAT = 4;
  localparam int HITS    = 3;
  localparam int TIMEOUT = 100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pen_i;
  logic [7:0] row_i, col_r_i, col_g_i;
  logic [2:0] pos_row_o, pos_col_o;
  logic       pos_valid_o, pen_err_o, pen_lost_o;

  pen_locator #(.PEN_LAT(PEN_LAT), .HITS(HITS), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .pen_i      (pen_i),
    .row_i      (row_i),
    .col_r_i    (col_r_i),
    .col_g_i    (col_g_i),
    .pos_row_o  (pos_row_o),
    .pos_col_o  (pos_col_o),
    .pos_valid_o(pos_valid_o),
    .pen_err_o  (pen_err_o),
    .pen_lost_o (pen_lost_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Pulse counters and width monitor, sampled on the falling edge.
  int n_valid = 0, n_err = 0, n_lost = 0, n_wide = 0;
  logic p_valid = 1'b0, p_err = 1'b0, p_lost = 1'b0;

  always @(negedge clk) begin
    if (pos_valid_o) n_valid++;
    if (pen_err_o)   n_err++;
    if (pen_lost_o)  n_lost++;
    if ((pos_valid_o && p_valid) || (pen_err_o && p_err) || (pen_lost_o && p_lost)) n_wide++;
    p_valid = pos_valid_o;
    p_err   = pen_err_o;
    p_lost  = pen_lost_o;
  end

  // Called at a falling edge: drives the pixel for one cycle (captured at edge
  // D), then raises the pen so it is detected PEN_LAT cycles later. Returns at
  // the second falling edge after the outputs update (update edge is D+5).
  task automatic hit(input logic [7:0] row, input logic [7:0] r, input logic [7:0] g,
                     input int hold);
    row_i = row; col_r_i = r; col_g_i = g;
    @(negedge clk);
    row_i = 8'hFF; col_r_i = 8'h00; col_g_i = 8'h00;
    repeat (PEN_LAT - 3) @(negedge clk);
    pen_i = 1'b1;
    repeat (hold) @(negedge clk);
    pen_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int vb, eb, lb, cyc;

  initial begin
    rst = 1'b1; pen_i = 1'b0; row_i = 8'hFF; col_r_i = 8'h00; col_g_i = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pos_row", pos_row_o, 0);
    check("rst_pos_col", pos_col_o, 0);
    check("rst_pulses", {pos_valid_o, pen_err_o, pen_lost_o}, 0);
    check("rst_state", dut.state, ST_IDLE);

    // Lock on (2,5) after three hits.
    hit(8'b1111_1011, 8'h20, 8'h00, 1);
    check("lock1_state", dut.state, ST_TRACK);
    check("lock1_hits", dut.hit_cnt, 1);
    hit(8'b1111_1011, 8'h20, 8'h00, 1);
    check("lock2_valid", n_valid, 0);
    hit(8'b1111_1011, 8'h20, 8'h00, 1);
    check("lock3_valid", n_valid, 1);
    check("lock3_row", pos_row_o, 2);
    check("lock3_col", pos_col_o, 5);
    check("lock3_state", dut.state, ST_LOCK);

    // Same pixel while locked: silent.
    hit(8'b1111_1011, 8'h20, 8'h00, 1);
    check("relock_valid", n_valid, 1);
    check("relock_state", dut.state, ST_LOCK);

    // Two rows selected: ambiguous tap.
    hit(8'b1111_1100, 8'h08, 8'h00, 1);
    check("amb_err", n_err, 1);
    check("amb_hits", dut.hit_cnt, 3);
    check("amb_cand", dut.cand, 6'o25);
    check("amb_state", dut.state, ST_LOCK);

    // Candidate change: (3,3) twice then (2,5) once.
    hit(8'b1111_0111, 8'h08, 8'h00, 1);
    check("chg1_state", dut.state, ST_TRACK);
    check("chg1_cand", dut.cand, 6'o33);
    hit(8'b1111_0111, 8'h08, 8'h00, 1);
    check("chg2_hits", dut.hit_cnt, 2);
    hit(8'b1111_1011, 8'h20, 8'h00, 1);
    check("chg3_valid", n_valid, 1);
    check("chg3_pos", {pos_row_o, pos_col_o}, 6'o25);
    check("chg3_state", dut.state, ST_TRACK);
    check("chg3_cand", dut.cand, 6'o25);
    check("chg3_hits", dut.hit_cnt, 1);

    // Latency: (1,1) one cycle before (6,6); the pen answers the second drive.
    row_i = 8'b1111_1101; col_r_i = 8'h02;
    @(negedge clk);
    hit(8'b1011_1111, 8'h40, 8'h00, 1);
    check("lat_cand", dut.cand, 6'o66);
    check("lat_hits", dut.hit_cnt, 1);

    // Lock on (6,6), then starve the pen until timeout.
    hit(8'b1011_1111, 8'h40, 8'h00, 1);
    hit(8'b1011_1111, 8'h40, 8'h00, 1);
    check("to_lock_valid", n_valid, 2);
    cyc = 1;
    while (!pen_lost_o && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("to_latency", cyc, TIMEOUT);
    @(negedge clk);
    check("to_lost_cnt", n_lost, 1);
    check("to_state", dut.state, ST_IDLE);
    check("to_pos", {pos_row_o, pos_col_o}, 6'o66);

    // Relock, then an ok edge exactly on cycle 100 suppresses the timeout.
    hit(8'b1011_1111, 8'h40, 8'h00, 1);
    hit(8'b1011_1111, 8'h40, 8'h00, 1);
    hit(8'b1011_1111, 8'h40, 8'h00, 1);
    check("to2_valid", n_valid, 3);
    repeat (93) @(negedge clk);
    hit(8'b1011_1111, 8'h40, 8'h00, 1);
    check("to2_no_lost", n_lost, 1);
    check("to2_state", dut.state, ST_LOCK);

    // Green-only pixel.
    eb = n_err;
    hit(8'hFE, 8'h00, 8'h01, 1);
`ifdef PEN_GREEN_EN
    check("green_err", n_err, eb);
    check("green_cand", dut.cand, 6'o00);
    check("green_state", dut.state, ST_TRACK);
`else
    check("green_err", n_err, eb + 1);
    check("green_cand", dut.cand, 6'o66);
    check("green_state", dut.state, ST_LOCK);
`endif

    // Held-high pen: one edge only (a second edge would see a blank tap).
    eb = n_err;
    hit(8'b1111_0111, 8'h08, 8'h00, 8);
    check("held_err", n_err, eb);
    check("held_hits", dut.hit_cnt, 1);
    check("held_cand", dut.cand, 6'o33);

    // Asynchronous reset in the middle of tracking.
    vb = n_valid; eb = n_err; lb = n_lost;
    #2 rst = 1'b1;
    #1;
    check("arst_state", dut.state, ST_IDLE);
    check("arst_pos", {pos_row_o, pos_col_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("arst_no_pulse", (n_valid - vb) + (n_err - eb) + (n_lost - lb), 0);
    check("arst_idle", dut.state, ST_IDLE);

    check("pulse_width", n_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pen_locator.md
# pen_locator

Light-pen position decoder for the 8×8 handwriting matrix. It watches the row and column drive that the matrix driver presents to the panel, and captures the pixel that was lit when the light pen fired, after compensating for the pen's response latency. It qualifies repeated hits on the same pixel before reporting a coordinate. It sits beside the LED matrix driver and is the receive end of the scan: the driver lights pixels, this block reports where the pen saw light.

## Interface
Parameters:
- `PEN_LAT`, default 4: pen response latency in clock cycles, legal range 0..15.
- `HITS`, default 3: consecutive same-pixel pen edges required to lock a position, legal range 1..15.
- `TIMEOUT`, default 5_000_000: cycles without a qualifying edge before tracking is dropped; counter is 24 bits.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `pen_i`  in  1  raw light-pen pulse, asynchronous to `clk`, high = light seen.
- `row_i`  in  8  matrix row drive, active-low; one 0 bit = selected row.
- `col_r_i`  in  8  red column drive, active-high.
- `col_g_i`  in  8  green column drive, active-high.
- `pos_row_o`  out  3  locked row index.
- `pos_col_o`  out  3  locked column index.
- `pos_valid_o`  out  1  one-cycle pulse when a new position locks.
- `pen_err_o`  out  1  one-cycle pulse on a pen edge with an ambiguous or blank tap.
- `pen_lost_o`  out  1  one-cycle pulse on timeout.

## Operation
- **Pixel decode:** computed every cycle.
  - lit = `col_r_i` | `col_g_i`.
  - ok = exactly one zero in `row_i` AND exactly one one in lit.
  - r/c = indices of those bits.
  - {ok,r,c} is registered into a delay line of depth `PEN_LAT`+1. The tap is the entry registered `PEN_LAT` cycles before the current entry.
- **Pen edge:** `pen_i` passes through a 2-flop synchronizer plus 1 history flop. An edge is ff2 & ~ff3.
- **FSM states:** IDLE, TRACK, LOCK. Registers: cand (6 b), hit_cnt (4 b), tcnt (24 b).
- **Any state, edge with tap ok=0:**
  - pulse `pen_err_o`;
  - state, cand and tcnt are unchanged.
- **IDLE, ok edge:**
  - cand←tap, hit_cnt←1, tcnt←0;
  - go to TRACK, or go straight to LOCK with a valid pulse if `HITS`=1.
- **TRACK, ok edge, tap==cand:**
  - hit_cnt+1;
  - when hit_cnt reaches `HITS`: load pos outputs from cand, pulse `pos_valid_o`, go to LOCK.
- **TRACK, ok edge, tap≠cand:** cand←tap, hit_cnt←1.
- **LOCK, ok edge, tap==cand:** no pulse; outputs hold.
- **LOCK, ok edge, tap≠cand:**
  - go to TRACK with cand←tap, hit_cnt←1;
  - `pos_row_o`/`pos_col_o` keep the last locked value.
- **Timeout counter (tcnt):**
  - clears on every ok edge;
  - increments each cycle in TRACK/LOCK;
  - held at 0 in IDLE.
- **Timeout:** when tcnt reaches `TIMEOUT`−1, go to IDLE, pulse `pen_lost_o`, clear hit_cnt. Position outputs hold.
- **Simultaneous ok edge and timeout:** the edge wins. The counter clears and there is no lost pulse.
- **hit_cnt:** saturates at `HITS`; it never wraps.

## Timing
- **Reset values:**
  - all outputs 0;
  - state IDLE;
  - delay line entries ok=0;
  - synchronizer flops 0.
- **Reset mid-operation:** reset asynchronously aborts any TRACK/LOCK. No pulse is emitted on reset release.
- **Edge detection:** a `pen_i` rise sampled by ff1 at clock edge E is detected during the cycle after edge E+2.
- **Output update:** registered outputs and pulses update at edge E+3.
- **Latency alignment:** drive presented at edge D is captured in the delay line at D; it is selected when the pen edge is detected at D+`PEN_LAT`.
- **Pulse width:** every pulse output is exactly 1 cycle wide.
- **Back-to-back edges:** a held-high `pen_i` produces one edge only. Edges on consecutive cycles are each processed.

## Configuration
- **`PEN_GREEN_EN` defined:** lit = `col_r_i` | `col_g_i`, as described above.
- **`PEN_GREEN_EN` not defined:**
  - lit = `col_r_i` only;
  - `col_g_i` is ignored;
  - a green-only pixel decodes ok=0, so a pen edge on it gives `pen_err_o`.

## Test plan
- **Lock:** `PEN_LAT`=4, `HITS`=3. Drive row_i=8'b1111_1011, col_r_i=8'h20; pen edges aligned 4 cycles later, three times → single `pos_valid_o`, pos_row_o=2, pos_col_o=5, state LOCK.
- **Latency:** drive pixel (1,1), then (6,6) on the next cycle. A pen edge aligned to the second drive → tap is (6,6), not (1,1).
- **Ambiguous tap:** row_i=8'b1111_1100 with one column active → `pen_err_o` pulse; hit_cnt and cand unchanged.
- **Candidate change:** in LOCK at (2,5), send 2 edges on (3,3) then 1 on (2,5) → no valid pulse. pos stays (2,5) and state is TRACK with cand (2,5), hit_cnt=1.
- **Timeout:** `TIMEOUT`=100, lock, then no edges → `pen_lost_o` exactly 100 cycles after the last ok edge; state IDLE; pos holds. A repeat run with an edge on cycle 100 → no lost pulse.
- **Macro off:** without `PEN_GREEN_EN`, col_r_i=0, col_g_i=8'h01, one row selected, pen edge → `pen_err_o`, no state change.
